// File: rtl/i2s_frame_sequencer.sv
// rtl/i2s_frame_sequencer.sv - master-mode I2S frame controller: BCLK/LRCLK divider, TX serialiser, RX deserialiser
module i2s_frame_sequencer #(
  parameter int BCLK_DIV   = 4,
  parameter int SLOT_BITS  = 32,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata_out,
  input  logic                  sdata_in,
  output logic                  underrun,
  output logic                  busy
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] L_FIRST    = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST     = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] R_FIRST    = BIT_W'(SLOT_BITS + 1);
  localparam logic [BIT_W-1:0] R_LAST     = BIT_W'(SLOT_BITS + DATA_WIDTH);
  localparam logic [BIT_W-1:0] SLOT_C     = BIT_W'(SLOT_BITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state, state_next;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   bclk_r;
  logic [DATA_WIDTH-1:0]  tx_sh_l, tx_sh_r;
  logic [DATA_WIDTH-1:0]  rx_sh_l, rx_sh_r;
  logic                   buf_full;
  logic [DATA_WIDTH-1:0]  buf_l, buf_r;

  logic rise_evt, fall_evt, frame_end, frame_start;
  logic in_left, in_right;

  always_comb begin
    state_next  = state;
    busy        = (state != S_IDLE);
    rise_evt    = busy && (div_cnt == DIV_LAST) && !bclk_r;
    fall_evt    = busy && (div_cnt == DIV_LAST) && bclk_r;
    frame_end   = fall_evt && (bit_cnt == FRAME_LAST);
    frame_start = 1'b0;
    in_left     = (bit_cnt >= L_FIRST) && (bit_cnt <= L_LAST);
    in_right    = (bit_cnt >= R_FIRST) && (bit_cnt <= R_LAST);
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next  = S_RUN;
          frame_start = 1'b1;
        end
      end
      S_RUN: begin
        frame_start = frame_end;
        if (!enable) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (enable) state_next = S_RUN;
        else if (frame_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One-bit I2S delay falls out of the bit windows starting at 1 and SLOT_BITS+1
  always_comb begin
    sdata_out = 1'b0;
    if (busy && in_left) sdata_out = tx_sh_l[DATA_WIDTH-1];
    else if (busy && in_right) sdata_out = tx_sh_r[DATA_WIDTH-1];
  end

  assign tx_ready = !buf_full;
  assign bclk     = bclk_r;
  assign lrclk    = busy && (bit_cnt >= SLOT_C);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      bclk_r   <= 1'b0;
      tx_sh_l  <= '0;
      tx_sh_r  <= '0;
      rx_sh_l  <= '0;
      rx_sh_r  <= '0;
      rx_left  <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else begin
      state    <= state_next;
      rx_valid <= 1'b0;
      underrun <= 1'b0;

      if (busy) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk_r  <= !bclk_r;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        bclk_r  <= 1'b0;
      end

      if (fall_evt) begin
        bit_cnt <= frame_end ? '0 : bit_cnt + BIT_W'(1);
        if (bit_cnt >= L_FIRST && bit_cnt < L_LAST) tx_sh_l <= {tx_sh_l[DATA_WIDTH-2:0], 1'b0};
        if (bit_cnt >= R_FIRST && bit_cnt < R_LAST) tx_sh_r <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
      end

      if (rise_evt) begin
        if (in_left)  rx_sh_l <= {rx_sh_l[DATA_WIDTH-2:0], sdata_in};
        if (in_right) rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], sdata_in};
      end

      if (frame_end) begin
        rx_left  <= rx_sh_l;
        rx_right <= rx_sh_r;
        rx_valid <= 1'b1;
      end

      if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_l    <= tx_left;
        buf_r    <= tx_right;
      end

      // Only a full buffer can be consumed, so this never collides with an accept
      if (frame_start) begin
        if (buf_full) begin
          tx_sh_l  <= buf_l;
          tx_sh_r  <= buf_r;
          buf_full <= 1'b0;
        end else begin
          tx_sh_l  <= '0;
          tx_sh_r  <= '0;
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb/tb_i2s_frame_sequencer.sv - directed self-checking bench for i2s_frame_sequencer
module tb_i2s_frame_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET, enable, tx_valid, tx_ready;
  logic [23:0] tx_left, tx_right, rx_left, rx_right;
  logic        rx_valid, bclk, lrclk, sdata_out, sdata_in, underrun, busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  // Loopback of the serial data pins
  assign sdata_in = sdata_out;

  i2s_frame_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_left(tx_left), .tx_right(tx_right),
    .rx_valid(rx_valid), .rx_left(rx_left), .rx_right(rx_right),
    .bclk(bclk), .lrclk(lrclk), .sdata_out(sdata_out), .sdata_in(sdata_in),
    .underrun(underrun), .busy(busy)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int lr_t, rx_t, end_t, hi, idx, n_und, n_rx;
  logic hs;
  logic [23:0] rxlog [0:3];

  initial begin
    ARESET = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_left = '0; tx_right = '0;
    tick(); tick();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata_out, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", underrun, 0);
    ARESET = 1'b0;

    // Loopback frame
    tx_valid = 1'b1; tx_left = 24'hA5F00F; tx_right = 24'h5A0FF0;
    tick();
    tx_valid = 1'b0;
    chk("wr_tx_ready_low", tx_ready, 0);
    enable = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_tx_ready", tx_ready, 1);
    chk("start_underrun", underrun, 0);
    repeat (7) tick();
    chk("t7_bclk", bclk, 1);
    chk("t7_sdata", sdata_out, 0);
    tick();
    chk("t8_bclk", bclk, 0);
    chk("t8_msb", sdata_out, 1);
    chk("t8_lrclk", lrclk, 0);
    lr_t = -1; rx_t = -1;
    for (int i = 9; i <= 600; i++) begin
      tick();
      if (lrclk && lr_t < 0) lr_t = i;
      if (rx_valid) begin rx_t = i; break; end
    end
    chk("lrclk_rise_t", lr_t, 256);
    chk("rx1_t", rx_t, 512);
    chk("rx1_left", rx_left, 32'hA5F00F);
    chk("rx1_right", rx_right, 32'h5A0FF0);
    chk("f2_underrun", underrun, 1);
    chk("f2_lrclk", lrclk, 0);

    // Frame with empty buffer
    hi = 0; rx_t = -1;
    for (int i = 513; i <= 1100; i++) begin
      tick();
      if (sdata_out) hi = 1;
      if (rx_valid) begin rx_t = i; break; end
    end
    chk("ur_rx_t", rx_t, 1024);
    chk("ur_sdata_hi", hi, 0);
    chk("ur_rx_left", rx_left, 0);
    chk("ur_underrun", underrun, 1);

    // Back-to-back samples with tx_valid held high
    idx = 0; n_und = 0; n_rx = 0;
    tx_valid = 1'b1; tx_left = 24'h000001; tx_right = 24'h100001;
    for (int i = 1; i <= 2047; i++) begin
      hs = tx_valid && tx_ready;
      tick();
      if (hs) begin
        idx++;
        if (idx == 3) tx_valid = 1'b0;
        else begin tx_left = 24'(idx + 1); tx_right = 24'h100000 + 24'(idx + 1); end
      end
      if (underrun) n_und++;
      if (rx_valid && n_rx < 4) begin rxlog[n_rx] = rx_left; n_rx++; end
    end
    chk("b2b_accepts", idx, 3);
    chk("b2b_underruns", n_und, 0);
    chk("b2b_rx_count", n_rx, 3);
    chk("b2b_rx0", rxlog[0], 0);
    chk("b2b_rx1", rxlog[1], 1);
    chk("b2b_rx2", rxlog[2], 2);
    tick();
    chk("b2b_rx3_valid", rx_valid, 1);
    chk("b2b_rx3_left", rx_left, 3);
    chk("b2b_rx3_right", rx_right, 32'h100003);
    chk("b2b_end_underrun", underrun, 1);

    // Drop enable mid-frame
    repeat (100) tick();
    enable = 1'b0;
    n_rx = 0; end_t = -1;
    for (int i = 3173; i <= 3800; i++) begin
      tick();
      if (rx_valid) n_rx++;
      if (!busy) begin end_t = i; break; end
    end
    chk("drain_end_t", end_t, 3584);
    chk("drain_rx_count", n_rx, 1);
    chk("drain_bclk", bclk, 0);
    repeat (20) tick();
    chk("idle_busy", busy, 0);
    chk("idle_bclk", bclk, 0);
    chk("idle_lrclk", lrclk, 0);
    chk("idle_rx_valid", rx_valid, 0);

    // Reset at bit_cnt 40
    enable = 1'b1;
    tick();
    chk("rs_start_underrun", underrun, 1);
    repeat (320) tick();
    chk("rs_lrclk_b40", lrclk, 1);
    tx_valid = 1'b1; tx_left = 24'h123456; tx_right = 24'h654321;
    tick();
    tx_valid = 1'b0;
    chk("rs_buf_full", tx_ready, 0);
    ARESET = 1'b1;
    tick();
    chk("rs_tx_ready", tx_ready, 1);
    chk("rs_busy", busy, 0);
    chk("rs_bclk", bclk, 0);
    chk("rs_lrclk", lrclk, 0);
    chk("rs_sdata", sdata_out, 0);
    chk("rs_rx_valid", rx_valid, 0);
    ARESET = 1'b0; enable = 1'b0;
    n_rx = 0;
    repeat (600) begin
      tick();
      if (rx_valid) n_rx++;
    end
    chk("rs_no_rx_valid", n_rx, 0);
    chk("rs_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
